// File: rtl/tlc_sensor_scheduler.sv
// Highway/farm-road traffic light controller with a pedestrian walk phase.
// Moore FSM: serves at most one pending side phase per highway interruption.
module tlc_sensor_scheduler #(
  parameter int unsigned T_HW_MIN   = 8,
  parameter int unsigned T_YEL      = 3,
  parameter int unsigned T_ALLRED   = 2,
  parameter int unsigned T_FARM     = 6,
  parameter int unsigned T_FARM_MAX = 12,
  parameter int unsigned T_WALK     = 5
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       farmSensor,
  input  logic       walkReq,
  output logic [1:0] highwaySignal,
  output logic [1:0] farmSignal,
  output logic       walkSignal,
  output logic [2:0] state,
  output logic [1:0] pending
);

  localparam int unsigned CW = 31;
  localparam int unsigned SW = 3;

  localparam logic [SW-1:0] S_HW_GREEN    = 3'd0;
  localparam logic [SW-1:0] S_HW_YELLOW   = 3'd1;
  localparam logic [SW-1:0] S_ALLRED_A    = 3'd2;
  localparam logic [SW-1:0] S_FARM_GREEN  = 3'd3;
  localparam logic [SW-1:0] S_FARM_YELLOW = 3'd4;
  localparam logic [SW-1:0] S_WALK        = 3'd5;
  localparam logic [SW-1:0] S_ALLRED_B    = 3'd6;

  localparam logic [1:0] LAMP_GREEN  = 2'b11;
  localparam logic [1:0] LAMP_YELLOW = 2'b10;
  localparam logic [1:0] LAMP_RED    = 2'b01;

  localparam logic [CW-1:0] HW_MIN_LAST   = CW'(T_HW_MIN - 1);
  localparam logic [CW-1:0] YEL_LAST      = CW'(T_YEL - 1);
  localparam logic [CW-1:0] ALLRED_LAST   = CW'(T_ALLRED - 1);
  localparam logic [CW-1:0] FARM_LAST     = CW'(T_FARM - 1);
  localparam logic [CW-1:0] FARM_MAX_LAST = CW'(T_FARM_MAX - 1);
  localparam logic [CW-1:0] WALK_LAST     = CW'(T_WALK - 1);
  localparam logic [CW-1:0] COUNT_SAT     = '1;

  logic [SW-1:0] state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic          farm_pend_q, farm_pend_d;
  logic          walk_pend_q, walk_pend_d;
  logic          last_walk_q, last_walk_d;
  logic          entering;

  // State register
  always_ff @(posedge Clk) begin
    if (Rst) state_q <= S_HW_GREEN;
    else     state_q <= state_d;
  end

  // Next-state logic; code 7 falls through to the default and recovers
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_HW_GREEN:
        if (count_q >= HW_MIN_LAST && (farm_pend_q || walk_pend_q)) state_d = S_HW_YELLOW;
      S_HW_YELLOW:
        if (count_q == YEL_LAST) state_d = S_ALLRED_A;
      S_ALLRED_A:
        if (count_q == ALLRED_LAST) begin
          if (farm_pend_q && (!walk_pend_q || last_walk_q)) state_d = S_FARM_GREEN;
          else if (walk_pend_q)                             state_d = S_WALK;
          else                                              state_d = S_ALLRED_B;
        end
      S_FARM_GREEN:
        if (count_q >= FARM_LAST && (!farmSensor || count_q == FARM_MAX_LAST))
          state_d = S_FARM_YELLOW;
      S_FARM_YELLOW:
        if (count_q == YEL_LAST) state_d = S_ALLRED_B;
      S_WALK:
        if (count_q == WALK_LAST) state_d = S_ALLRED_B;
      S_ALLRED_B:
        if (count_q == ALLRED_LAST) state_d = S_HW_GREEN;
      default:
        state_d = S_HW_GREEN;
    endcase
  end

  // Phase timer, request latches and fairness bit; entry clears win over new requests
  always_comb begin
    entering    = (state_d != state_q);
    count_d     = entering ? '0 : ((count_q == COUNT_SAT) ? count_q : count_q + CW'(1));
    farm_pend_d = farm_pend_q | (farmSensor && state_q != S_FARM_GREEN);
    walk_pend_d = walk_pend_q | (walkReq && state_q != S_WALK);
    last_walk_d = last_walk_q;
    if (entering && state_d == S_FARM_GREEN) begin
      farm_pend_d = 1'b0;
      last_walk_d = 1'b0;
    end
    if (entering && state_d == S_WALK) begin
      walk_pend_d = 1'b0;
      last_walk_d = 1'b1;
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      count_q     <= '0;
      farm_pend_q <= 1'b0;
      walk_pend_q <= 1'b0;
      last_walk_q <= 1'b1;
    end else begin
      count_q     <= count_d;
      farm_pend_q <= farm_pend_d;
      walk_pend_q <= walk_pend_d;
      last_walk_q <= last_walk_d;
    end
  end

  // Lamp decode from the state register only
  always_comb begin
    highwaySignal = LAMP_RED;
    farmSignal    = LAMP_RED;
    walkSignal    = 1'b0;
    state         = state_q;
    pending       = {walk_pend_q, farm_pend_q};
    unique case (state_q)
      S_HW_GREEN:    highwaySignal = LAMP_GREEN;
      S_HW_YELLOW:   highwaySignal = LAMP_YELLOW;
      S_FARM_GREEN:  farmSignal    = LAMP_GREEN;
      S_FARM_YELLOW: farmSignal    = LAMP_YELLOW;
      S_WALK:        walkSignal    = 1'b1;
      default:       ;
    endcase
  end

endmodule

// File: tb/tb_tlc_sensor_scheduler.sv
// Bench for tlc_sensor_scheduler: per-cycle reference model plus directed
// scenarios with hand-computed state timelines.
module tb_tlc_sensor_scheduler;

  logic       Clk = 1'b0;
  logic       Rst;
  logic       farmSensor;
  logic       walkReq;
  logic [1:0] highwaySignal;
  logic [1:0] farmSignal;
  logic       walkSignal;
  logic [2:0] state;
  logic [1:0] pending;

  tlc_sensor_scheduler dut (
    .Clk(Clk), .Rst(Rst), .farmSensor(farmSensor), .walkReq(walkReq),
    .highwaySignal(highwaySignal), .farmSignal(farmSignal), .walkSignal(walkSignal),
    .state(state), .pending(pending)
  );

  always #5 Clk = ~Clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: phases 0..6, time-in-phase, request flags, who was served last
  localparam int HG = 0, HY = 1, AA = 2, FG = 3, FY = 4, WK = 5, AB = 6;
  localparam int SAT = 2147483647;
  int m_ph, m_t;
  bit m_fp, m_wp, m_last_walk;
  bit m_valid = 0;

  always @(posedge Clk) begin
    int nph;
    bit nfp, nwp;
    if (Rst) begin
      m_ph = HG; m_t = 0; m_fp = 0; m_wp = 0; m_last_walk = 1;
    end else begin
      nph = m_ph;
      case (m_ph)
        HG: if (m_t >= 7 && (m_fp || m_wp)) nph = HY;
        HY: if (m_t == 2) nph = AA;
        AA: if (m_t == 1) nph = (m_fp && (!m_wp || m_last_walk)) ? FG : (m_wp ? WK : AB);
        FG: if (m_t >= 5 && (!farmSensor || m_t == 11)) nph = FY;
        FY: if (m_t == 2) nph = AB;
        WK: if (m_t == 4) nph = AB;
        AB: if (m_t == 1) nph = HG;
        default: nph = HG;
      endcase
      nfp = m_fp || (farmSensor && m_ph != FG);
      nwp = m_wp || (walkReq && m_ph != WK);
      if (nph != m_ph) begin
        m_t = 0;
        if (nph == FG) begin nfp = 0; m_last_walk = 0; end
        if (nph == WK) begin nwp = 0; m_last_walk = 1; end
      end else if (m_t != SAT) begin
        m_t++;
      end
      m_ph = nph; m_fp = nfp; m_wp = nwp;
    end
    m_valid = 1;
  end

  // Compare every cycle, away from the active edge
  always @(negedge Clk) begin
    if (m_valid) begin
      chk("state", int'(state), m_ph);
      chk("highwaySignal", int'(highwaySignal), m_ph == HG ? 3 : (m_ph == HY ? 2 : 1));
      chk("farmSignal", int'(farmSignal), m_ph == FG ? 3 : (m_ph == FY ? 2 : 1));
      chk("walkSignal", int'(walkSignal), (m_ph == WK) ? 1 : 0);
      chk("pending", int'(pending), int'({m_wp, m_fp}));
      chk("count", int'(dut.count_q), m_t);
    end
  end

  int c;

  task automatic to_cyc(input int target);
    while (c < target) begin
      @(negedge Clk);
      c++;
    end
  endtask

  // One reset edge, then release in post-reset cycle 0
  task automatic do_reset();
    @(negedge Clk);
    Rst = 1; farmSensor = 0; walkReq = 0;
    @(negedge Clk);
    chk("rst_state", int'(state), 0);
    chk("rst_hw_lamp", int'(highwaySignal), 3);
    chk("rst_farm_lamp", int'(farmSignal), 1);
    chk("rst_walk_lamp", int'(walkSignal), 0);
    Rst = 0;
    c = 0;
  endtask

  initial begin
    Rst = 1; farmSensor = 0; walkReq = 0;

    // Idle: highway stays green
    do_reset();
    to_cyc(200);
    chk("idle_state", int'(state), 0);
    chk("idle_hw", int'(highwaySignal), 3);

    // Single farm pulse at cycle 2
    do_reset();
    to_cyc(2);  farmSensor = 1;
    to_cyc(3);  farmSensor = 0;
    to_cyc(7);  chk("pulse_c7", int'(state), HG);
    to_cyc(8);  chk("pulse_c8", int'(state), HY);
    to_cyc(11); chk("pulse_c11", int'(state), AA);
    to_cyc(12); chk("pulse_c12", int'(state), AA);
    to_cyc(13); chk("pulse_c13", int'(state), FG);
    to_cyc(18); chk("pulse_c18", int'(state), FG);
    to_cyc(19); chk("pulse_c19", int'(state), FY);
    to_cyc(21); chk("pulse_c21", int'(state), FY);
    to_cyc(22); chk("pulse_c22", int'(state), AB);
    to_cyc(23); chk("pulse_c23", int'(state), AB);
    to_cyc(24); chk("pulse_c24", int'(state), HG);

    // Farm sensor held: green capped at 12 cycles, pending re-sets in yellow
    do_reset();
    to_cyc(2);  farmSensor = 1;
    to_cyc(13); chk("hold_c13", int'(state), FG);
    to_cyc(24); chk("hold_c24", int'(state), FG);
    to_cyc(25); chk("hold_c25", int'(state), FY);
    to_cyc(26); chk("hold_fp_c26", int'(pending[0]), 1);
    farmSensor = 0;
    to_cyc(45);

    // Farm and walk together: farm first, walk on the next interruption
    do_reset();
    to_cyc(2);  farmSensor = 1; walkReq = 1;
    to_cyc(3);  farmSensor = 0; walkReq = 0;
    to_cyc(13); chk("both_c13", int'(state), FG);
    to_cyc(18); chk("both_c18", int'(state), FG);
                chk("both_pend_c18", int'(pending), 2);
    to_cyc(24); chk("both_c24", int'(state), HG);
    to_cyc(31); chk("both_c31", int'(state), HG);
    to_cyc(32); chk("both_c32", int'(state), HY);
    to_cyc(37); chk("both_c37", int'(state), WK);
                chk("both_walk_c37", int'(walkSignal), 1);
    to_cyc(41); chk("both_walk_c41", int'(walkSignal), 1);
    to_cyc(42); chk("both_c42", int'(state), AB);
                chk("both_walk_c42", int'(walkSignal), 0);
    to_cyc(50);

    // Reset in the third farm-green cycle; request during reset discarded
    do_reset();
    to_cyc(2);  farmSensor = 1;
    to_cyc(3);  farmSensor = 0;
    to_cyc(15); chk("rst_mid_c15", int'(state), FG);
    Rst = 1; walkReq = 1;
    to_cyc(16);
    chk("rst_mid_state", int'(state), 0);
    chk("rst_mid_count", int'(dut.count_q), 0);
    chk("rst_mid_pend", int'(pending), 0);
    chk("rst_mid_farm", int'(farmSignal), 1);
    chk("rst_mid_hw", int'(highwaySignal), 3);
    Rst = 0; walkReq = 0;
    to_cyc(30);
    chk("rst_mid_idle", int'(state), 0);

    // Walk held across entry: absorbed, re-latched once WALK ends
    do_reset();
    to_cyc(2);  walkReq = 1;
    to_cyc(13); chk("wh_c13", int'(state), WK);
                chk("wh_wp_c13", int'(pending[1]), 0);
    to_cyc(17); chk("wh_wp_c17", int'(pending[1]), 0);
    to_cyc(18); chk("wh_c18", int'(state), AB);
    to_cyc(19); chk("wh_wp_c19", int'(pending[1]), 1);
    to_cyc(20); walkReq = 0;
                chk("wh_c20", int'(state), HG);
    to_cyc(40);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/tlc_sensor_scheduler.md
TLC_SENSOR_SCHEDULER -- requirements
Module: tlc_sensor_scheduler

Interface
REQ-001 Parameter T_HW_MIN, default 8: minimum highway green length, in cycles.
REQ-002 Parameter T_YEL, default 3: yellow length, in cycles.
REQ-003 Parameter T_ALLRED, default 2: all-red clearance length, in cycles.
REQ-004 Parameter T_FARM, default 6: minimum farm green length, in cycles.
REQ-005 Parameter T_FARM_MAX, default 12: maximum farm green length, in cycles; T_FARM_MAX SHALL be >= T_FARM.
REQ-006 Parameter T_WALK, default 5: pedestrian walk length, in cycles.
REQ-007 Clk  input  1  single clock; all state changes on its rising edge.
REQ-008 Rst  input  1  reset, synchronous, active-high.
REQ-009 farmSensor  input  1  farm-road car present (already synchronous to Clk).
REQ-010 walkReq  input  1  pedestrian request, level or pulse (already synchronous).
REQ-011 highwaySignal  output  2  highway lamp: 2'b11 green, 2'b10 yellow, 2'b01 red.
REQ-012 farmSignal  output  2  farm lamp, same encoding as highwaySignal.
REQ-013 walkSignal  output  1  walk lamp, 1 = walk.
REQ-014 state  output  3  current FSM state, for debug.
REQ-015 pending  output  2  {walkPending, farmPending}, for debug.

Function
REQ-016 The block SHALL be a Moore FSM; lamps decode from the state register only.
REQ-017 States SHALL be: 0 HW_GREEN, 1 HW_YELLOW, 2 ALLRED_A, 3 FARM_GREEN, 4 FARM_YELLOW, 5 WALK, 6 ALLRED_B. Code 7 is illegal and SHALL go to HW_GREEN.
REQ-018 Lamp outputs per state:
- HW_GREEN: highway green, farm red.
- HW_YELLOW: highway yellow, farm red.
- FARM_GREEN: highway red, farm green.
- FARM_YELLOW: highway red, farm yellow.
- ALLRED_A, ALLRED_B, WALK: both red.
- walkSignal SHALL be 1 only in WALK.
REQ-019 Internal 31-bit Count SHALL be 0 in the first cycle of every state, SHALL increment by 1 each cycle, and SHALL saturate at 2^31-1.
REQ-020 farmPending SHALL set when farmSensor=1 in any state except FARM_GREEN; walkPending SHALL set when walkReq=1 in any state except WALK.
REQ-021 farmPending SHALL clear on entry to FARM_GREEN; walkPending SHALL clear on entry to WALK; a request in the entry cycle itself SHALL be absorbed, not latched.
REQ-022 HW_GREEN -> HW_YELLOW when Count >= T_HW_MIN-1 and (farmPending or walkPending); otherwise stay, indefinitely.
REQ-023 HW_YELLOW -> ALLRED_A at Count == T_YEL-1.
REQ-024 ALLRED_A at Count == T_ALLRED-1 SHALL grant:
- FARM_GREEN if farmPending and (not walkPending or lastServed = walk);
- else WALK if walkPending;
- else ALLRED_B.
REQ-025 lastServed SHALL update to farm on entry to FARM_GREEN and to walk on entry to WALK; its reset value is walk, so farm wins the first tie.
REQ-026 FARM_GREEN -> FARM_YELLOW when Count >= T_FARM-1 and (farmSensor=0 or Count == T_FARM_MAX-1).
REQ-027 FARM_YELLOW -> ALLRED_B at Count == T_YEL-1; WALK -> ALLRED_B at Count == T_WALK-1; ALLRED_B -> HW_GREEN at Count == T_ALLRED-1.
REQ-028 Only one phase SHALL be served per highway interruption; a request left unserved SHALL stay pending until the next HW_GREEN minimum expires.
REQ-029 Implementation SHALL be 120-400 lines of RTL.

Reset
REQ-030 Rst=1 at a rising edge SHALL force state=HW_GREEN, Count=0, pending=2'b00, lastServed=walk, from any state, in the next cycle.
REQ-031 While Rst=1, outputs SHALL read highwaySignal=2'b11, farmSignal=2'b01, walkSignal=0.
REQ-032 Requests sampled while Rst=1 SHALL be discarded.

Verification (default parameters)
REQ-033 Idle: no requests for 200 cycles after reset -> state stays 0, highwaySignal=2'b11 throughout.
REQ-034 One-cycle farmSensor pulse at cycle 2 -> state sequence:
- HW_YELLOW at cycle 8;
- ALLRED_A for 2 cycles;
- FARM_GREEN for exactly 6 cycles;
- FARM_YELLOW for 3 cycles;
- ALLRED_B for 2 cycles;
- then HW_GREEN.
REQ-035 farmSensor held high -> FARM_GREEN lasts exactly 12 cycles, then FARM_YELLOW; farmPending re-sets during FARM_YELLOW.
REQ-036 farmSensor and walkReq pulsed together -> FARM_GREEN is served first, with walkPending=1 held through it. The next interruption, after 8 HW_GREEN cycles, serves WALK for 5 cycles with walkSignal=1, then ALLRED_B.
REQ-037 Rst asserted during cycle 3 of FARM_GREEN -> next cycle state=0, Count=0, pending=2'b00, farmSignal=2'b01.
REQ-038 walkReq held high across WALK entry -> walkPending stays 0 in the entry cycle and re-sets on the first ALLRED_B cycle.
